wb_arbiter: RTL and testbench

- Shares the single writeback/CDB port between N execution units (ALU0, ALU1, branch unit, ...).
- Each requester presents a registered WB payload with a valid/ready handshake. The arbiter picks one per cycle by round-robin and latches it into a 1-entry output buffer that drives the CDB/ROB writeback.
- Stale-epoch results are drained and discarded so they never occupy the bus.

---
 rtl/wb_arbiter.sv | 95 +++++++++
 tb/tb_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing the writeback/CDB port, with a
// 1-entry output buffer and stale-epoch draining.
module wb_arbiter #(
    parameter int N       = 3,
    parameter int IDX_W   = (N > 1) ? $clog2(N) : 1,
    parameter int ROB_W   = 6,
    parameter int PHYS_W  = 7,
    parameter int EPOCH_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*32-1:0]      req_pc,
    input  logic [N-1:0]         req_uses_rd,
    input  logic [N*ROB_W-1:0]   req_rob_idx,
    input  logic [N*PHYS_W-1:0]  req_prd_new,
    input  logic [N*EPOCH_W-1:0] req_epoch,
    input  logic [N*32-1:0]      req_data,
    input  logic [EPOCH_W-1:0]   cur_epoch,
    input  logic                 flush_valid,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output logic [31:0]          cdb_pc,
    output logic                 cdb_uses_rd,
    output logic [ROB_W-1:0]     cdb_rob_idx,
    output logic [PHYS_W-1:0]    cdb_prd_new,
    output logic [EPOCH_W-1:0]   cdb_epoch,
    output logic [31:0]          cdb_data,
    output logic [IDX_W-1:0]     cdb_src
);
    logic             out_vld;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt;
    logic [N-1:0]     live;
    logic [N-1:0]     stale;
    logic [N-1:0]     gnt_oh;
    logic             match;
    logic             can_acc;

    always_comb begin
        live  = '0;
        stale = '0;
        for (int i = 0; i < N; i++) begin
            live[i]  = req_valid[i] && (req_epoch[EPOCH_W*i +: EPOCH_W] == cur_epoch);
            stale[i] = req_valid[i] && (req_epoch[EPOCH_W*i +: EPOCH_W] != cur_epoch);
        end
    end

    assign match     = cdb_epoch == cur_epoch;
    assign cdb_valid = out_vld && match;
    // A buffered entry whose epoch went stale is dropped, so it counts as free.
    assign can_acc   = (!out_vld || !match || cdb_ready) && !flush_valid;

    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (can_acc && !gnt && live[(int'(rr_ptr) + k) % N]) begin
                gnt     = 1'b1;
                gnt_idx = IDX_W'((int'(rr_ptr) + k) % N);
            end
        end
    end

    assign gnt_oh    = gnt ? (N'(1) << gnt_idx) : '0;
    assign req_ready = rst ? '0 : (stale | gnt_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld     <= 1'b0;
            rr_ptr      <= '0;
            cdb_pc      <= '0;
            cdb_uses_rd <= 1'b0;
            cdb_rob_idx <= '0;
            cdb_prd_new <= '0;
            cdb_epoch   <= '0;
            cdb_data    <= '0;
            cdb_src     <= '0;
        end else if (gnt) begin
            out_vld     <= 1'b1;
            rr_ptr      <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
            cdb_pc      <= req_pc[32*int'(gnt_idx) +: 32];
            cdb_uses_rd <= req_uses_rd[gnt_idx];
            cdb_rob_idx <= req_rob_idx[ROB_W*int'(gnt_idx) +: ROB_W];
            cdb_prd_new <= req_prd_new[PHYS_W*int'(gnt_idx) +: PHYS_W];
            cdb_epoch   <= req_epoch[EPOCH_W*int'(gnt_idx) +: EPOCH_W];
            cdb_data    <= req_data[32*int'(gnt_idx) +: 32];
            cdb_src     <= gnt_idx;
        end else if (flush_valid || !match || cdb_ready) begin
            out_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed test-plan steps followed by random traffic, all
// checked against a transaction-level model of the arbiter.
module tb_wb_arbiter;
    localparam int N = 3, IDX_W = 2, ROB_W = 6, PHYS_W = 7, EPOCH_W = 2;

    logic clk = 1'b0;
    logic rst, flush, cdb_ready;
    logic [EPOCH_W-1:0] cur_epoch;
    logic [N-1:0] v, ur, req_ready;
    logic [31:0] pc [N];
    logic [31:0] dat [N];
    logic [ROB_W-1:0] rob [N];
    logic [PHYS_W-1:0] prd [N];
    logic [EPOCH_W-1:0] ep [N];
    logic [N*32-1:0] req_pc, req_data;
    logic [N*ROB_W-1:0] req_rob_idx;
    logic [N*PHYS_W-1:0] req_prd_new;
    logic [N*EPOCH_W-1:0] req_epoch;
    logic cdb_valid, cdb_uses_rd;
    logic [31:0] cdb_pc, cdb_data;
    logic [ROB_W-1:0] cdb_rob_idx;
    logic [PHYS_W-1:0] cdb_prd_new;
    logic [EPOCH_W-1:0] cdb_epoch;
    logic [IDX_W-1:0] cdb_src;

    always #5 clk = ~clk;

    always_comb begin
        req_pc = '0;
        req_data = '0;
        req_rob_idx = '0;
        req_prd_new = '0;
        req_epoch = '0;
        for (int i = 0; i < N; i++) begin
            req_pc[32*i +: 32] = pc[i];
            req_data[32*i +: 32] = dat[i];
            req_rob_idx[ROB_W*i +: ROB_W] = rob[i];
            req_prd_new[PHYS_W*i +: PHYS_W] = prd[i];
            req_epoch[EPOCH_W*i +: EPOCH_W] = ep[i];
        end
    end

    wb_arbiter #(.N(N), .IDX_W(IDX_W), .ROB_W(ROB_W), .PHYS_W(PHYS_W), .EPOCH_W(EPOCH_W)) dut (
        .clk(clk), .rst(rst), .req_valid(v), .req_ready(req_ready), .req_pc(req_pc),
        .req_uses_rd(ur), .req_rob_idx(req_rob_idx), .req_prd_new(req_prd_new),
        .req_epoch(req_epoch), .req_data(req_data), .cur_epoch(cur_epoch),
        .flush_valid(flush), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_pc(cdb_pc), .cdb_uses_rd(cdb_uses_rd), .cdb_rob_idx(cdb_rob_idx),
        .cdb_prd_new(cdb_prd_new), .cdb_epoch(cdb_epoch), .cdb_data(cdb_data),
        .cdb_src(cdb_src)
    );

    typedef struct {
        logic [31:0] pc;
        logic ur;
        logic [ROB_W-1:0] rob;
        logic [PHYS_W-1:0] prd;
        logic [EPOCH_W-1:0] ep;
        logic [31:0] dat;
        int src;
    } ent_t;

    ent_t m_buf = '{default: 0};
    bit m_vld = 0;
    int m_ptr = 0;
    bit gnt = 0;
    int g = 0;
    bit e_cv = 0;
    logic [N-1:0] e_rdy = '0;
    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic newp(input int i);
        pc[i] = $urandom;
        dat[i] = $urandom;
        rob[i] = ROB_W'($urandom);
        prd[i] = PHYS_W'($urandom);
        ur[i] = 1'($urandom);
    endtask

    // Predict this cycle's handshakes from the model state, then compare.
    task automatic at_neg();
        bit acc;
        @(negedge clk);
        e_cv = m_vld && (m_buf.ep == cur_epoch);
        acc = !flush && (!m_vld || (e_cv && cdb_ready) || (m_vld && m_buf.ep != cur_epoch));
        gnt = 0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            int u = (m_ptr + k) % N;
            if (acc && !gnt && v[u] && ep[u] == cur_epoch) begin
                gnt = 1;
                g = u;
            end
        end
        e_rdy = '0;
        for (int i = 0; i < N; i++) e_rdy[i] = v[i] && ep[i] != cur_epoch;
        if (gnt) e_rdy[g] = 1'b1;
        if (rst) e_rdy = '0;
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("cdb_valid", 64'(cdb_valid), 64'(e_cv));
        chk("cdb_pc", 64'(cdb_pc), 64'(m_buf.pc));
        chk("cdb_uses_rd", 64'(cdb_uses_rd), 64'(m_buf.ur));
        chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_buf.rob));
        chk("cdb_prd_new", 64'(cdb_prd_new), 64'(m_buf.prd));
        chk("cdb_epoch", 64'(cdb_epoch), 64'(m_buf.ep));
        chk("cdb_data", 64'(cdb_data), 64'(m_buf.dat));
        chk("cdb_src", 64'(cdb_src), 64'(m_buf.src));
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            m_vld = 0;
            m_ptr = 0;
            m_buf = '{default: 0};
        end else if (gnt) begin
            m_vld = 1;
            m_buf = '{pc: pc[g], ur: ur[g], rob: rob[g], prd: prd[g], ep: ep[g], dat: dat[g], src: g};
            m_ptr = (g + 1) % N;
        end else if (flush || (e_cv && cdb_ready) || (m_vld && m_buf.ep != cur_epoch)) begin
            m_vld = 0;
        end
        #1;
    endtask

    initial begin
        rst = 1; flush = 0; cdb_ready = 0; cur_epoch = 0; v = '1;
        for (int i = 0; i < N; i++) begin newp(i); ep[i] = 0; end
        @(posedge clk); #1;
        at_neg(); chk("rst_ready", 64'(req_ready), 64'(0)); edge_step();
        // 1: back-to-back round robin
        rst = 0; cdb_ready = 1;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            chk("p1_gnt", 64'(req_ready), 64'(3'b001 << (c % 3)));
            if (c > 0) begin
                chk("p1_src", 64'(cdb_src), 64'((c - 1) % 3));
                chk("p1_vld", 64'(cdb_valid), 64'(1));
            end
            edge_step();
        end
        v = '0; at_neg(); edge_step();
        // 2: backpressure holds the buffer
        v = 3'b010; dat[1] = 32'hDEAD_BEEF; rob[1] = 5; cdb_ready = 0;
        at_neg(); chk("p2_gnt", 64'(req_ready), 64'(3'b010)); edge_step();
        dat[1] = 32'h1111; rob[1] = 6;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("p2_vld", 64'(cdb_valid), 64'(1));
            chk("p2_data", 64'(cdb_data), 64'(32'hDEAD_BEEF));
            chk("p2_rob", 64'(cdb_rob_idx), 64'(5));
            chk("p2_rdy", 64'(req_ready), 64'(0));
            edge_step();
        end
        cdb_ready = 1; v = 3'b011;
        at_neg(); chk("p2_next", 64'(req_ready), 64'(3'b001)); edge_step();
        v = '0; at_neg(); edge_step();
        // 3: stale requester drained, live one granted
        cur_epoch = 1; v = 3'b101; ep[0] = 0; ep[2] = 1; rob[0] = 9; rob[2] = 12;
        at_neg(); chk("p3_rdy", 64'(req_ready), 64'(3'b101)); edge_step();
        v = '0; cdb_ready = 0;
        at_neg();
        chk("p3_src", 64'(cdb_src), 64'(2));
        chk("p3_vld", 64'(cdb_valid), 64'(1));
        chk("p3_rob", 64'(cdb_rob_idx), 64'(12));
        edge_step();
        // 4: epoch change suppresses the held entry and frees the slot
        cur_epoch = 2; v = 3'b001; ep[0] = 2; rob[0] = 20;
        at_neg();
        chk("p4_vld", 64'(cdb_valid), 64'(0));
        chk("p4_gnt", 64'(req_ready), 64'(3'b001));
        edge_step();
        v = '0;
        at_neg();
        chk("p4_src", 64'(cdb_src), 64'(0));
        chk("p4_rob", 64'(cdb_rob_idx), 64'(20));
        edge_step();
        // 5: flush blocks grants and keeps the pointer
        v = 3'b110; ep[1] = 2; ep[2] = 2; flush = 1;
        at_neg(); chk("p5_rdy", 64'(req_ready), 64'(0)); edge_step();
        flush = 0;
        at_neg();
        chk("p5_vld", 64'(cdb_valid), 64'(0));
        chk("p5_gnt", 64'(req_ready), 64'(3'b010));
        edge_step();
        // 6: reset with a buffered entry and rr_ptr=2
        rst = 1; v = 3'b111; ep[0] = 2; newp(1);
        at_neg(); chk("p6_rdy", 64'(req_ready), 64'(0)); edge_step();
        rst = 0; cdb_ready = 1;
        at_neg();
        chk("p6_vld", 64'(cdb_valid), 64'(0));
        chk("p6_gnt", 64'(req_ready), 64'(3'b001));
        edge_step();
        // random traffic
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom % 64) == 0;
            flush = ($urandom % 10) == 0;
            cdb_ready = ($urandom % 3) != 0;
            if (($urandom % 16) == 0) cur_epoch = cur_epoch + 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!v[i] || e_rdy[i]) begin
                    v[i] = ($urandom % 3) != 0;
                    newp(i);
                    ep[i] = (($urandom % 4) == 0) ? EPOCH_W'(cur_epoch - 1'b1) : cur_epoch;
                end
            end
            at_neg();
            edge_step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
